// File: rtl/ddr4_cmd_decoder_if.sv
// Pin-level command bus between the DDR4 command source and the decoder,
// carrying the raw control pins in and the decoded, registered results out.
interface ddr4_cmd_decoder_if #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int ERRW    = 16
);
    localparam int BANKS = 2 ** (BGWIDTH + BAWIDTH);

    logic               cke;
    logic               cs_n;
    logic               act_n;
    logic               ras_n;
    logic               cas_n;
    logic               we_n;
    logic               a10;
    logic [BGWIDTH-1:0] bg;
    logic [BAWIDTH-1:0] ba;
    logic [18:0]        commands;
    logic [BGWIDTH-1:0] bg_q;
    logic [BAWIDTH-1:0] ba_q;
    logic               cmd_err;
    logic [ERRW-1:0]    err_count;
    logic [BANKS-1:0]   bank_open;
    logic [1:0]         pd_state;

    modport master (
        output cke, cs_n, act_n, ras_n, cas_n, we_n, a10, bg, ba,
        input  commands, bg_q, ba_q, cmd_err, err_count, bank_open, pd_state
    );

    modport slave (
        input  cke, cs_n, act_n, ras_n, cas_n, we_n, a10, bg, ba,
        output commands, bg_q, ba_q, cmd_err, err_count, bank_open, pd_state
    );
endinterface

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command decoder: raw pins to a one-hot command vector, with power-down
// tracking, per-bank open status and illegal-command suppression; 1-cycle latency.
module ddr4_cmd_decoder #(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int ERRW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    ddr4_cmd_decoder_if.slave bus
);
    localparam int BW    = BGWIDTH + BAWIDTH;
    localparam int BANKS = 2 ** BW;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_PWRDN   = 2'd1;
    localparam logic [1:0] ST_SELFREF = 2'd2;

    localparam int C_ACT  = 18;
    localparam int C_CFG  = 16;
    localparam int C_CKEH = 15;
    localparam int C_MRW  = 10;
    localparam int C_PD   = 9;
    localparam int C_PDX  = 8;
    localparam int C_PR   = 7;
    localparam int C_PRA  = 6;
    localparam int C_RD   = 5;
    localparam int C_RDA  = 4;
    localparam int C_REF  = 3;
    localparam int C_SRF  = 2;
    localparam int C_WR   = 1;
    localparam int C_WRA  = 0;

    logic [18:0]        cmd_q, cmd_d;
    logic               err_q, err_d;
    logic [BANKS-1:0]   open_q, open_d;
    logic [1:0]         pd_q, pd_d;
    logic [ERRW-1:0]    cnt_q, cnt_d;
    logic               cke_q;
    logic [BGWIDTH-1:0] bg_out_q;
    logic [BAWIDTH-1:0] ba_out_q;

    logic [BW-1:0] idx;
    logic [2:0]    rcw;
    logic          any_open;
    logic          hit;
    logic          des_nop;
    logic          ref_enc;

    assign idx      = {bus.bg, bus.ba};
    assign rcw      = {bus.ras_n, bus.cas_n, bus.we_n};
    assign any_open = |open_q;
    assign hit      = open_q[idx];
    assign des_nop  = bus.cs_n || (bus.act_n && (rcw == 3'b111));
    assign ref_enc  = !bus.cs_n && bus.act_n && (rcw == 3'b001);

    always_comb begin
        cmd_d  = '0;
        err_d  = 1'b0;
        open_d = open_q;
        pd_d   = pd_q;
        if (pd_q == ST_NORMAL) begin
            if (cke_q && !bus.cke) begin
                // Entering low power: only a clean REF selects self-refresh.
                if (ref_enc && !any_open) begin
                    cmd_d[C_SRF] = 1'b1;
                    pd_d         = ST_SELFREF;
                end else begin
                    cmd_d[C_PD] = 1'b1;
                    pd_d        = ST_PWRDN;
                    err_d       = !des_nop;
                end
            end else if (bus.cke && !bus.cs_n) begin
                if (!bus.act_n) begin
                    if (hit) err_d = 1'b1;
                    else begin
                        cmd_d[C_ACT] = 1'b1;
                        open_d[idx]  = 1'b1;
                    end
                end else begin
                    case (rcw)
                        3'b000: if (any_open) err_d = 1'b1; else cmd_d[C_MRW] = 1'b1;
                        3'b001: if (any_open) err_d = 1'b1; else cmd_d[C_REF] = 1'b1;
                        3'b010: begin
                            if (bus.a10) begin
                                cmd_d[C_PRA] = 1'b1;
                                open_d       = '0;
                            end else if (!hit) err_d = 1'b1;
                            else begin
                                cmd_d[C_PR] = 1'b1;
                                open_d[idx] = 1'b0;
                            end
                        end
                        3'b011: err_d = 1'b1;
                        3'b100: begin
                            if (!hit) err_d = 1'b1;
                            else if (bus.a10) begin
                                cmd_d[C_WRA] = 1'b1;
                                open_d[idx]  = 1'b0;
                            end else cmd_d[C_WR] = 1'b1;
                        end
                        3'b101: begin
                            if (!hit) err_d = 1'b1;
                            else if (bus.a10) begin
                                cmd_d[C_RDA] = 1'b1;
                                open_d[idx]  = 1'b0;
                            end else cmd_d[C_RD] = 1'b1;
                        end
                        3'b110: if (any_open) err_d = 1'b1; else cmd_d[C_CFG] = 1'b1;
                        default: ;
                    endcase
                end
            end
        end else if (bus.cke) begin
            // Exit cycle: the pins are swallowed, only the exit pulse is issued.
            if (pd_q == ST_PWRDN) cmd_d[C_PDX] = 1'b1;
            else cmd_d[C_CKEH] = 1'b1;
            err_d = !des_nop;
            pd_d  = ST_NORMAL;
        end
    end

    assign cnt_d = (err_d && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q    <= '0;
            err_q    <= 1'b0;
            open_q   <= '0;
            pd_q     <= ST_NORMAL;
            cnt_q    <= '0;
            cke_q    <= 1'b1;
            bg_out_q <= '0;
            ba_out_q <= '0;
        end else begin
            cmd_q    <= cmd_d;
            err_q    <= err_d;
            open_q   <= open_d;
            pd_q     <= pd_d;
            cnt_q    <= cnt_d;
            cke_q    <= bus.cke;
            bg_out_q <= bus.bg;
            ba_out_q <= bus.ba;
        end
    end

    assign bus.commands  = cmd_q;
    assign bus.cmd_err   = err_q;
    assign bus.err_count = cnt_q;
    assign bus.bank_open = open_q;
    assign bus.pd_state  = pd_q;
    assign bus.bg_q      = bg_out_q;
    assign bus.ba_q      = ba_out_q;
endmodule
